// File: rtl/spi_arb2_pkg.sv
// spi_arb_pkg: shared types and constants for the two-client SPI arbiter
package spi_arb_pkg;
    typedef enum logic [1:0] {GAP, IDLE, WAIT_CLR, BUSY} arb_state_t;
    localparam int GUARD_DEF = 4;
    localparam int GUARD_W = 4;
endpackage

// File: rtl/spi_arb2_if.sv
// spi_arb2_if: client request/grant signals and SPI master strobe/data bundled together
interface spi_arb2_if;
    logic        req0;
    logic        req1;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [15:0] rd_data0;
    logic [15:0] rd_data1;
    logic        wrt;
    logic [15:0] cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    modport slave (
        input  req0, req1, cmd0, cmd1, spi_done, spi_rd_data,
        output gnt0, gnt1, done0, done1, rd_data0, rd_data1, wrt, cmd
    );
    modport master (
        output req0, req1, cmd0, cmd1, spi_done, spi_rd_data,
        input  gnt0, gnt1, done0, done1, rd_data0, rd_data1, wrt, cmd
    );
endinterface

// File: rtl/spi_arb2_rr_pick2.sv
// rr_pick2: two-way round-robin pick; sel=1 selects client 1
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic sel
);
    assign any = req0 | req1;
    assign sel = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/spi_arb2.sv
// spi_arb2: shares one SPI master between two clients with round-robin grants,
// a single-cycle wrt per grant and a guard gap between transactions.
module spi_arb2
    import spi_arb_pkg::*;
#(
    parameter int GUARD = GUARD_DEF
) (
    input logic      clk,
    input logic      rst_n,
    spi_arb2_if.slave bus
);
    arb_state_t         r_state;
    arb_state_t         w_nxt;
    logic [GUARD_W-1:0] r_cnt;
    logic               r_last;
    logic               r_wrt;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_done0;
    logic               r_done1;
    logic [15:0]        r_cmd;
    logic [15:0]        r_rd0;
    logic [15:0]        r_rd1;
    logic               w_any;
    logic               w_sel;
    logic               w_grant;
    logic               w_finish;

    rr_pick2 u_pick (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (r_last),
        .any  (w_any),
        .sel  (w_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= GAP;
        else        r_state <= w_nxt;
    end

    // WAIT_CLR ignores the stale high done left over from the previous transfer
    always_comb begin
        w_nxt    = r_state;
        w_grant  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            GAP:      w_nxt = (r_cnt == GUARD_W'(GUARD - 1)) ? IDLE : GAP;
            IDLE: begin
                w_grant = w_any;
                w_nxt   = w_any ? WAIT_CLR : IDLE;
            end
            WAIT_CLR: w_nxt = bus.spi_done ? WAIT_CLR : BUSY;
            BUSY: begin
                w_finish = bus.spi_done;
                w_nxt    = bus.spi_done ? GAP : BUSY;
            end
            default:  w_nxt = GAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_wrt   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_cmd   <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_cnt   <= (r_state == GAP) ? r_cnt + 1'b1 : '0;
            r_wrt   <= w_grant;
            r_done0 <= w_finish & r_gnt0;
            r_done1 <= w_finish & r_gnt1;
            if (w_grant) begin
                r_gnt0 <= ~w_sel;
                r_gnt1 <= w_sel;
                r_cmd  <= w_sel ? bus.cmd1 : bus.cmd0;
            end
            if (w_finish) begin
                r_gnt0 <= 1'b0;
                r_gnt1 <= 1'b0;
                r_last <= r_gnt1;
                r_rd0  <= r_gnt0 ? bus.spi_rd_data : r_rd0;
                r_rd1  <= r_gnt1 ? bus.spi_rd_data : r_rd1;
            end
        end
    end

    assign bus.wrt      = r_wrt;
    assign bus.cmd      = r_cmd;
    assign bus.gnt0     = r_gnt0;
    assign bus.gnt1     = r_gnt1;
    assign bus.done0    = r_done0;
    assign bus.done1    = r_done1;
    assign bus.rd_data0 = r_rd0;
    assign bus.rd_data1 = r_rd1;
endmodule

// File: tb/tb_spi_arb2.sv
// tb_spi_arb2: directed scenarios against a behavioural SPI master model
module tb_spi_arb2;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    spi_arb2_if bus();

    spi_arb2 #(.GUARD(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          stale_n = 0;
    int          busy_n = 3;
    logic [15:0] rd_val = 16'h00C3;
    int          wrt_cnt = 0;
    int          d0_cnt = 0;
    int          d1_cnt = 0;

    // Master model: done idles high, drops after wrt (optionally late), rises with data
    initial begin
        bus.spi_done    = 1'b1;
        bus.spi_rd_data = '0;
        forever begin
            @(negedge clk);
            if (bus.wrt && rst_n) begin
                repeat (stale_n) @(negedge clk);
                bus.spi_done = 1'b0;
                repeat (busy_n) @(negedge clk);
                bus.spi_rd_data = rd_val;
                bus.spi_done    = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.wrt) wrt_cnt++;
        if (bus.done0) d0_cnt++;
        if (bus.done1) d1_cnt++;
        n_cmp++;
        if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1)) begin
            n_bad++;
            $display("FAIL exclusive: gnt=%b%b done=%b%b required no pair high", bus.gnt0, bus.gnt1, bus.done0, bus.done1);
        end
    end

    task automatic apply_reset();
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = '0;
        bus.cmd1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_wrt(input int max, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus.wrt) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_any_done(input int max, output int who, output int cyc);
        who = -1;
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                who = bus.done1 ? 1 : 0;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = '0;
        bus.cmd1 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.wrt} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b required 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.wrt});
        end
        n_cmp++;
        if (bus.cmd !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_cmd: got %h required 0000", bus.cmd);
        end
        n_cmp++;
        if ({bus.rd_data0, bus.rd_data1} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rd: got %h required 00000000", {bus.rd_data0, bus.rd_data1});
        end
    endtask

    task automatic test_first();
        int cyc;
        int who;
        apply_reset();
        bus.req0 = 1'b1;
        bus.cmd0 = 16'hA5F0;
        rd_val   = 16'h00C3;
        wait_wrt(30, cyc);
        n_cmp++;
        if (cyc !== G + 1) begin
            n_bad++;
            $display("FAIL first_wrt_time: got %0d required %0d", cyc, G + 1);
        end
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.cmd} !== {2'b10, 16'hA5F0}) begin
            n_bad++;
            $display("FAIL first_grant: got gnt=%b%b cmd=%h required 10 a5f0", bus.gnt0, bus.gnt1, bus.cmd);
        end
        wait_any_done(30, who, cyc);
        bus.req0 = 1'b0;
        n_cmp++;
        if (who !== 0 || cyc !== busy_n + 1) begin
            n_bad++;
            $display("FAIL first_done: got who=%0d cyc=%0d required 0 %0d", who, cyc, busy_n + 1);
        end
        n_cmp++;
        if (bus.rd_data0 !== 16'h00C3 || bus.gnt0 !== 1'b0) begin
            n_bad++;
            $display("FAIL first_data: got rd0=%h gnt0=%b required 00c3 0", bus.rd_data0, bus.gnt0);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done0 !== 1'b0 || bus.rd_data1 !== 16'h0000) begin
            n_bad++;
            $display("FAIL first_pulse: got done0=%b rd1=%h required 0 0000", bus.done0, bus.rd_data1);
        end
    endtask

    task automatic test_alternate();
        int cyc;
        int who;
        int w0;
        apply_reset();
        bus.cmd0 = 16'h0A0A;
        bus.cmd1 = 16'h1B1B;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_val = 16'h1000 + 16'(i);
            w0 = wrt_cnt;
            wait_wrt(30, cyc);
            n_cmp++;
            if (cyc !== G + 1) begin
                n_bad++;
                $display("FAIL alt_gap%0d: got %0d required %0d", i, cyc, G + 1);
            end
            n_cmp++;
            if (bus.cmd !== ((i % 2 == 0) ? 16'h0A0A : 16'h1B1B)) begin
                n_bad++;
                $display("FAIL alt_cmd%0d: got %h", i, bus.cmd);
            end
            wait_any_done(30, who, cyc);
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            n_cmp++;
            if (who !== i % 2) begin
                n_bad++;
                $display("FAIL alt_order%0d: got %0d required %0d", i, who, i % 2);
            end
            n_cmp++;
            if (((i % 2 == 0) ? bus.rd_data0 : bus.rd_data1) !== 16'h1000 + 16'(i)) begin
                n_bad++;
                $display("FAIL alt_rd%0d: got %h/%h required %h", i, bus.rd_data0, bus.rd_data1, 16'h1000 + 16'(i));
            end
            n_cmp++;
            if (wrt_cnt - w0 !== 1) begin
                n_bad++;
                $display("FAIL alt_wrts%0d: got %0d required 1", i, wrt_cnt - w0);
            end
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_stale();
        int cyc;
        int who;
        int d0;
        stale_n  = 3;
        busy_n   = 2;
        rd_val   = 16'hBEEF;
        d0       = d0_cnt;
        bus.cmd0 = 16'h5A5A;
        bus.req0 = 1'b1;
        wait_wrt(30, cyc);
        wait_any_done(30, who, cyc);
        bus.req0 = 1'b0;
        n_cmp++;
        if (who !== 0 || cyc !== 6) begin
            n_bad++;
            $display("FAIL stale_done: got who=%0d cyc=%0d required 0 6", who, cyc);
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (d0_cnt - d0 !== 1 || bus.rd_data0 !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL stale_count: got %0d rd0=%h required 1 beef", d0_cnt - d0, bus.rd_data0);
        end
        stale_n = 0;
        busy_n  = 3;
    endtask

    task automatic test_drop();
        int cyc;
        int who;
        int w0;
        rd_val   = 16'h3C3C;
        bus.cmd1 = 16'h7777;
        bus.req1 = 1'b1;
        wait_wrt(30, cyc);
        n_cmp++;
        if (cyc < 1 || bus.gnt1 !== 1'b1 || bus.cmd !== 16'h7777) begin
            n_bad++;
            $display("FAIL drop_grant: got cyc=%0d gnt1=%b cmd=%h required >0 1 7777", cyc, bus.gnt1, bus.cmd);
        end
        @(negedge clk);
        bus.req1 = 1'b0;
        wait_any_done(30, who, cyc);
        n_cmp++;
        if (who !== 1 || bus.rd_data1 !== 16'h3C3C) begin
            n_bad++;
            $display("FAIL drop_done: got who=%0d rd1=%h required 1 3c3c", who, bus.rd_data1);
        end
        w0 = wrt_cnt;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (wrt_cnt !== w0 || bus.gnt1 !== 1'b0 || bus.rd_data0 !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL drop_after: got wrts=%0d gnt1=%b rd0=%h required 0 0 beef", wrt_cnt - w0, bus.gnt1, bus.rd_data0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int who;
        busy_n   = 8;
        bus.cmd1 = 16'h1234;
        bus.req1 = 1'b1;
        wait_wrt(30, cyc);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.wrt} !== 5'b0 || bus.cmd !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_ctl: got ctl=%b cmd=%h required 00000 0000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.wrt}, bus.cmd);
        end
        n_cmp++;
        if ({bus.rd_data0, bus.rd_data1} !== 32'h0) begin
            n_bad++;
            $display("FAIL async_rd: got %h required 00000000", {bus.rd_data0, bus.rd_data1});
        end
        bus.cmd0 = 16'h0F0F;
        bus.req0 = 1'b1;
        repeat (12) @(negedge clk);
        busy_n = 3;
        rd_val = 16'h4242;
        rst_n  = 1'b1;
        wait_wrt(30, cyc);
        n_cmp++;
        if (cyc !== G + 1 || bus.gnt0 !== 1'b1 || bus.cmd !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL rst_tie: got cyc=%0d gnt0=%b cmd=%h required %0d 1 0f0f", cyc, bus.gnt0, bus.cmd, G + 1);
        end
        wait_any_done(30, who, cyc);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_cmp++;
        if (who !== 0 || bus.rd_data0 !== 16'h4242) begin
            n_bad++;
            $display("FAIL rst_done: got who=%0d rd0=%h required 0 4242", who, bus.rd_data0);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_cmd_hold();
        int cyc;
        int bad_cmd;
        bad_cmd  = 0;
        rd_val   = 16'h9999;
        bus.cmd0 = 16'h1111;
        bus.req0 = 1'b1;
        wait_wrt(30, cyc);
        @(posedge clk);
        #1 bus.cmd0 = 16'h2222;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd !== 16'h1111) bad_cmd++;
            if (bus.done0) break;
        end
        bus.req0 = 1'b0;
        n_cmp++;
        if (bad_cmd !== 0 || bus.done0 !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_hold: got %0d bad cycles done0=%b required 0 1", bad_cmd, bus.done0);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (bus.cmd !== 16'h1111 || bus.rd_data0 !== 16'h9999) begin
            n_bad++;
            $display("FAIL cmd_idle: got cmd=%h rd0=%h required 1111 9999", bus.cmd, bus.rd_data0);
        end
    endtask

    initial begin
        test_reset();
        test_first();
        test_alternate();
        test_stale();
        test_drop();
        test_reset_mid();
        test_cmd_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
